// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, marks them done from the
// common data bus, and retires at most one done entry per cycle from the head,
// writing the register file through registered outputs.
// Optional feature: define ROB_QUERY_EN to add a tag query port with same-cycle
// CDB forwarding.
module reorder_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             flush_in,
  output logic             to_rf_we,
  output logic [4:0]       to_rf_rd,
  output logic [31:0]      to_rf_wdata,
  output logic             empty
`ifdef ROB_QUERY_EN
  ,
  input  logic [TAG_W-1:0] query_tag,
  output logic             query_ready,
  output logic [31:0]      query_value
`endif
);

  localparam logic [TAG_W:0] CntFull = (TAG_W+1)'(DEPTH);

  // Control state
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Entry payload (no reset needed: only read when the valid bit is set)
  logic             has_rd_q [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      value_q  [DEPTH];

  // Registered register-file write port
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic alloc_fire;
  logic cdb_hit;
  logic commit_fire;

  // Handshake and event qualification; every decision uses pre-edge state.
  always_comb begin
    alloc_ready = (count_q < CntFull) && !flush_in;
    alloc_tag   = tail_q;
    empty       = (count_q == '0);
    alloc_fire  = alloc_valid && alloc_ready && rdy_in;
    cdb_hit     = cdb_valid && rdy_in && !flush_in && valid_q[cdb_tag];
    // Done must already be set before the edge, so a same-edge CDB write waits a cycle.
    commit_fire = rdy_in && !flush_in && valid_q[head_q] && done_q[head_q];
  end

  // Next-state for pointers, count, entry flags and the register-file port.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    done_d     = done_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        valid_d = '0;
        done_d  = '0;
      end else begin
        if (cdb_hit) begin
          done_d[cdb_tag] = 1'b1;
        end
        if (commit_fire) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
          rf_we_d         = has_rd_q[head_q] && (rd_q[head_q] != 5'd0);
          rf_rd_d         = rd_q[head_q];
          rf_wdata_d      = value_q[head_q];
        end
        if (alloc_fire) begin
          valid_d[tail_q] = 1'b1;
          done_d[tail_q]  = 1'b0;
          tail_d          = tail_q + 1'b1;
        end
        unique case ({alloc_fire, commit_fire})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Entry payload: destination captured on allocate, result on completion.
  always_ff @(posedge clk_in) begin
    if (alloc_fire) begin
      has_rd_q[tail_q] <= alloc_has_rd;
      rd_q[tail_q]     <= alloc_rd;
    end
    if (cdb_hit) begin
      value_q[cdb_tag] <= cdb_value;
    end
  end

  assign to_rf_we    = rf_we_q;
  assign to_rf_rd    = rf_rd_q;
  assign to_rf_wdata = rf_wdata_q;

`ifdef ROB_QUERY_EN
  logic query_fwd;

  // Query lookup with same-cycle forwarding from the CDB.
  always_comb begin
    query_fwd   = cdb_valid && (cdb_tag == query_tag);
    query_ready = query_fwd || (valid_q[query_tag] && done_q[query_tag]);
    query_value = query_fwd ? cdb_value : value_q[query_tag];
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed sequences with a scoreboard
// of expected register-file writes, popped as the DUT pulses to_rf_we.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        alloc_valid;
  logic        alloc_has_rd;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        flush_in;
  logic        to_rf_we;
  logic [4:0]  to_rf_rd;
  logic [31:0] to_rf_wdata;
  logic        empty;

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .alloc_valid (alloc_valid),
    .alloc_has_rd(alloc_has_rd),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .flush_in    (flush_in),
    .to_rf_we    (to_rf_we),
    .to_rf_rd    (to_rf_rd),
    .to_rf_wdata (to_rf_wdata),
    .empty       (empty)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0] tag;
    logic [4:0] rd;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mval[8];
  logic [2:0]  mtail;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Allocate one entry; accept says whether the model expects it to be taken.
  task automatic do_alloc(input logic has, input logic [4:0] rd, input logic accept);
    alloc_valid  = 1'b1;
    alloc_has_rd = has;
    alloc_rd     = rd;
    if (accept) begin
      if (has && rd != 5'd0) sb_q.push_back('{tag: mtail, rd: rd});
      mtail = mtail + 3'd1;
    end
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input logic [2:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    mval[tag] = val;
    step();
    cdb_valid = 1'b0;
  endtask

  // Write-back monitor: every pulse must match the oldest expected write.
  always @(negedge clk_in) begin
    if (rst_in && to_rf_we) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_extra", 32'(to_rf_we), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_eq("wb_rd", 32'(to_rf_rd), 32'(e.rd));
        check_eq("wb_data", to_rf_wdata, mval[e.tag]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; alloc_valid = 1'b0; alloc_has_rd = 1'b0;
    alloc_rd = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; flush_in = 1'b0;
    mtail = '0;
    for (int i = 0; i < 8; i++) mval[i] = '0;
    #12;
    check_eq("rst_we", 32'(to_rf_we), 32'd0);
    check_eq("rst_rd", 32'(to_rf_rd), 32'd0);
    check_eq("rst_wdata", to_rf_wdata, 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_tag", 32'(alloc_tag), 32'd0);
    rst_in = 1'b1;
    step();

    // Basic alloc -> complete -> commit, three edges end to end.
    do_alloc(1'b1, 5'd5, 1'b1);
    check_eq("t1_tag", 32'(alloc_tag), 32'(mtail));
    check_eq("t1_nempty", 32'(empty), 32'd0);
    do_complete(3'd0, 32'h1234);
    check_eq("t1_nocommit_cdb_edge", 32'(to_rf_we), 32'd0);
    step();
    check_eq("t1_we", 32'(to_rf_we), 32'd1);
    check_eq("t1_rd", 32'(to_rf_rd), 32'd5);
    check_eq("t1_wdata", to_rf_wdata, 32'h1234);
    check_eq("t1_empty", 32'(empty), 32'd1);
    step();
    check_eq("t1_pulse", 32'(to_rf_we), 32'd0);

    // Fill to full; ninth request ignored; full count blocks a same-edge alloc.
    for (int i = 1; i <= 8; i++) do_alloc(1'b1, 5'(i), 1'b1);
    check_eq("t2_full_ready", 32'(alloc_ready), 32'd0);
    do_alloc(1'b1, 5'd31, 1'b0);
    check_eq("t2_ninth_tag", 32'(alloc_tag), 32'(mtail));
    check_eq("t2_ninth_ready", 32'(alloc_ready), 32'd0);
    do_complete(3'd1, 32'h0000_00a0);
    check_eq("t2_nocommit_yet", 32'(to_rf_we), 32'd0);
    alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd31;
    step();
    alloc_valid = 1'b0;
    check_eq("t2_commit_we", 32'(to_rf_we), 32'd1);
    check_eq("t2_commit_rd", 32'(to_rf_rd), 32'd1);
    check_eq("t2_ready_after", 32'(alloc_ready), 32'd1);
    check_eq("t2_tag_after", 32'(alloc_tag), 32'(mtail));

    // Out-of-order completion, in-order commit on consecutive edges.
    do_complete(3'd4, 32'h404);
    check_eq("t3_we_c4", 32'(to_rf_we), 32'd0);
    do_complete(3'd3, 32'h403);
    check_eq("t3_we_c3", 32'(to_rf_we), 32'd0);
    do_complete(3'd2, 32'h402);
    check_eq("t3_we_c2", 32'(to_rf_we), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_eq("t3_we", 32'(to_rf_we), 32'd1);
      check_eq("t3_rd", 32'(to_rf_rd), 32'(i));
      check_eq("t3_wdata", to_rf_wdata, 32'h400 + 32'(i));
    end
    step();
    check_eq("t3_idle", 32'(to_rf_we), 32'd0);

    // Four outstanding (tags 5,6,7,0), two completed off-head, then flush with alloc.
    do_complete(3'd6, 32'h606);
    do_complete(3'd7, 32'h707);
    check_eq("t4_pre_we", 32'(to_rf_we), 32'd0);
    flush_in = 1'b1; alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd9;
    #1;
    check_eq("t4_flush_ready", 32'(alloc_ready), 32'd0);
    step();
    flush_in = 1'b0; alloc_valid = 1'b0;
    sb_q.delete();
    mtail = '0;
    check_eq("t4_empty", 32'(empty), 32'd1);
    check_eq("t4_we", 32'(to_rf_we), 32'd0);
    check_eq("t4_tag", 32'(alloc_tag), 32'd0);
    step();
    check_eq("t4_we2", 32'(to_rf_we), 32'd0);

    // rd=0 and has_rd=0 entries retire silently.
    do_alloc(1'b1, 5'd0, 1'b1);
    do_alloc(1'b0, 5'd7, 1'b1);
    do_complete(3'd0, 32'h55);
    do_complete(3'd1, 32'h66);
    check_eq("t5_we_a", 32'(to_rf_we), 32'd0);
    step();
    check_eq("t5_we_b", 32'(to_rf_we), 32'd0);
    check_eq("t5_empty", 32'(empty), 32'd1);

    // rdy_in low holds everything, including a done head entry.
    do_alloc(1'b1, 5'd12, 1'b1);
    do_complete(3'd2, 32'hbeef);
    rdy_in = 1'b0; alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_hold_we", 32'(to_rf_we), 32'd0);
      check_eq("t6_hold_empty", 32'(empty), 32'd0);
      check_eq("t6_hold_tag", 32'(alloc_tag), 32'(mtail));
    end
    alloc_valid = 1'b0; rdy_in = 1'b1;
    step();
    check_eq("t6_we", 32'(to_rf_we), 32'd1);
    check_eq("t6_rd", 32'(to_rf_rd), 32'd12);
    check_eq("t6_wdata", to_rf_wdata, 32'hbeef);
    check_eq("t6_empty", 32'(empty), 32'd1);

    // Reset mid-flight discards a done entry before it can commit.
    do_alloc(1'b1, 5'd3, 1'b1);
    do_complete(3'd3, 32'h77);
    #2;
    rst_in = 1'b0;
    #1;
    sb_q.delete();
    mtail = '0;
    check_eq("t7_we", 32'(to_rf_we), 32'd0);
    check_eq("t7_empty", 32'(empty), 32'd1);
    check_eq("t7_tag", 32'(alloc_tag), 32'd0);
    check_eq("t7_rd", 32'(to_rf_rd), 32'd0);
    check_eq("t7_wdata", to_rf_wdata, 32'd0);
    step();
    rst_in = 1'b1;
    step();
    check_eq("t7_we_after", 32'(to_rf_we), 32'd0);
    step();
    check_eq("t7_we_after2", 32'(to_rf_we), 32'd0);
    check_eq("t7_empty_after", 32'(empty), 32'd1);

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, entry count, power of two.
REQ-002 Parameter: TAG_W, default 3, log2(DEPTH).
REQ-003 clk_in  input  1  clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  reset; asynchronous and active-low.
REQ-005 rdy_in  input  1  global ready; low = hold all state.
REQ-006 alloc_valid  input  1  the decoder requests a new entry.
REQ-007 alloc_has_rd  input  1  the instruction writes a destination register.
REQ-008 alloc_rd  input  5  destination register index.
REQ-009 alloc_ready  output  1  combinational; high when count < DEPTH and flush_in is low.
REQ-010 alloc_tag  output  TAG_W  combinational; equals the tail pointer, which is the tag of the entry being allocated.
REQ-011 cdb_valid  input  1  result broadcast valid.
REQ-012 cdb_tag  input  TAG_W  tag of the entry that completed.
REQ-013 cdb_value  input  32  result value.
REQ-014 flush_in  input  1  mispredict flush.
REQ-015 to_rf_we  output  1  registered; register-file write enable.
REQ-016 to_rf_rd  output  5  registered; register-file write index.
REQ-017 to_rf_wdata  output  32  registered; register-file write data.
REQ-018 empty  output  1  combinational; high when count == 0.

Function
REQ-019 Storage: circular buffer of DEPTH entries. Per-entry fields: valid, done, has_rd, rd[4:0], value[31:0]. Control: head, tail (TAG_W bits, wrap modulo DEPTH) and count (TAG_W+1 bits).
REQ-020 Allocate: on an edge with alloc_valid & alloc_ready & rdy_in, write entry[tail] with valid=1, done=0 and the rd fields, then tail+1.
REQ-021 alloc_valid while alloc_ready is low is ignored; no state changes.
REQ-022 Complete: on an edge with cdb_valid & rdy_in & entry[cdb_tag].valid, set done=1 and value=cdb_value.
REQ-023 cdb_valid aimed at an invalid entry is ignored.
REQ-024 Commit: on an edge where entry[head].valid & done & rdy_in, retire the entry: valid=0, head+1.
REQ-025 At most one commit per cycle; commit is strictly in order.
REQ-026 Register-file write on commit: to_rf_we<=1, to_rf_rd<=rd, to_rf_wdata<=value on the same edge as retirement.
REQ-027 When has_rd=0 or rd=0, the commit retires the entry with to_rf_we<=0.
REQ-028 to_rf_we<=0 on every edge with no qualifying commit; the outputs are single-cycle pulses.
REQ-029 Latency: a CDB write at edge N makes that head entry commit at edge N+1, with to_rf_we visible after N+1. The minimum from alloc to to_rf_we is 3 edges.
REQ-030 Count update: alloc and commit on the same edge leave count unchanged; alloc only gives +1; commit only gives -1.
REQ-031 Full: alloc_ready is computed from the pre-edge count, so a commit on the same edge does not admit an alloc.
REQ-032 A CDB write to the head entry on the same edge does not commit it that edge.
REQ-033 Flush: on an edge with flush_in & rdy_in, all valid bits clear, head=tail=count=0 and to_rf_we<=0.
REQ-034 Flush priority: flush overrides alloc, complete and commit on the same edge.
REQ-035 rdy_in low: pointers, count, entries and the to_rf_rd / to_rf_wdata outputs hold; to_rf_we<=0.

Reset
REQ-036 While rst_in is low, asynchronously: all valid and done bits=0, head=tail=count=0, to_rf_we=0, to_rf_rd=0, to_rf_wdata=0.
REQ-037 A reset asserted mid-operation discards all in-flight entries; no write to the register file occurs.

Configuration
REQ-038 Macro ROB_QUERY_EN adds these ports:
- query_tag  input  TAG_W
- query_ready  output  1  combinational; entry[query_tag].valid & done
- query_value  output  32  combinational; entry value
REQ-039 With ROB_QUERY_EN defined, a cdb_valid whose cdb_tag equals query_tag forwards in the same cycle: query_ready=1, query_value=cdb_value.
REQ-040 Without ROB_QUERY_EN, these ports are absent and there is no bypass logic.

Verification
REQ-041 Reset, then alloc rd=5, CDB tag0 value 0x1234 -> one to_rf_we pulse with rd=5 and wdata=0x1234 after the third edge; empty=1 afterwards.
REQ-042 Alloc 8 entries -> alloc_ready=0 and a 9th alloc_valid is ignored. Complete tag0 -> commit at the next edge; alloc_ready=1 after that edge.
REQ-043 Complete tags 2,1,0 in that order -> commits occur in order 0,1,2 on consecutive edges with the matching rd/wdata.
REQ-044 Alloc with rd=0 and another with has_rd=0, then complete both -> both retire; to_rf_we stays 0.
REQ-045 Fill 4 entries, complete 2, assert flush_in together with alloc_valid -> count=0, no to_rf_we, alloc_tag=0 on the next cycle.
REQ-046 Hold rdy_in=0 while the head entry is done -> no commit and to_rf_we=0; raising rdy_in -> commit on the next edge.
